// File: rtl/dmem_pkg.sv
// ============================================================================
// Module : dmem_pkg
// Brief  : func3 codes, FSM state encoding and sizing helpers for data_mem_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } dmem_state_t;

  function automatic int lanes_of(input int dw);
    return dw / 8;
  endfunction

  function automatic int off_of(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic logic [3:0] f3_bytes(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

  // Unsigned stores and doubleword forms on a 32-bit build are illegal.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we, input logic wide64);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      F3_D:             return wide64;
      F3_WU:            return wide64 && !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_if.sv
// ============================================================================
// Module : dmem_if
// Brief  : Request/response bus between the MEM stage and data_mem_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_func3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_func3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/dmem_load_align.sv
// ============================================================================
// Module : dmem_load_align
// Brief  : Shifts the addressed lanes of one or two raw words down and
//          sign/zero-extends them according to func3.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]           raw_lo,
  input  logic [DATA_W-1:0]           raw_hi,
  input  logic [off_of(DATA_W)-1:0]   off,
  input  logic [2:0]                  func3,
  output logic [DATA_W-1:0]           result
);

  logic [2*DATA_W-1:0] w_wide;
  logic [DATA_W-1:0]   w_sh;
  logic [DATA_W-1:0]   w_left;
  logic [7:0]          w_bits;
  logic [7:0]          w_pad;

  // Extension is done by pushing the field to the MSB and shifting it back.
  always_comb begin
    w_wide = {raw_hi, raw_lo} >> {off, 3'b000};
    w_sh   = w_wide[DATA_W-1:0];
    w_bits = 8'd8 << func3[1:0];
    w_pad  = (w_bits >= 8'(DATA_W)) ? 8'd0 : 8'(DATA_W) - w_bits;
    w_left = w_sh << w_pad;
    if (func3[2])
      result = w_left >> w_pad;
    else
      result = DATA_W'($signed(w_left) >>> w_pad);
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module : data_mem_ctrl
// Brief  : MEM-stage data memory with valid/ready request and 1-cycle
//          registered response. Define DMEM_SPLIT_EN to split word-crossing
//          misaligned accesses instead of flagging them as errors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.slave  bus
);

  localparam int LANES = lanes_of(DATA_W);
  localparam int OFF   = off_of(DATA_W);
  localparam int AW    = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic                w_accept;
  logic [OFF-1:0]      w_off;
  logic [AW-1:0]       w_idx;
  logic [3:0]          w_nbytes;
  logic                w_legal;
  logic                w_misal;
  logic                w_cross;
  logic                w_err;
  logic                w_split;
  logic [15:0]         w_mask16;
  logic [2*LANES-1:0]  w_be_wide;
  logic [2*DATA_W-1:0] w_wd_wide;
  logic                w_addr_unused;

  logic [AW-1:0]       w_mem_idx;
  logic                w_wr_en;
  logic [LANES-1:0]    w_wr_be;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_rd_en;
  logic                w_in_split;

  logic [DATA_W-1:0]   r_raw_lo;
  logic                r_rsp_valid;
  logic                r_err;
  logic                r_load;
  logic [OFF-1:0]      r_off;
  logic [2:0]          r_func3;
  logic [DATA_W-1:0]   w_aligned;

  assign w_accept  = bus.req_valid && bus.req_ready;
  assign w_off     = bus.req_addr[OFF-1:0];
  assign w_idx     = bus.req_addr[OFF+AW-1:OFF];
  assign w_nbytes  = f3_bytes(bus.req_func3);
  assign w_legal   = f3_legal(bus.req_func3, bus.req_we, DATA_W == 64);
  assign w_misal   = (w_off & OFF'(w_nbytes - 4'd1)) != '0;
  assign w_cross   = (5'(w_off) + 5'(w_nbytes)) > 5'(LANES);
  assign w_mask16  = (16'd1 << w_nbytes) - 16'd1;
  assign w_be_wide = (2*LANES)'(w_mask16) << w_off;
  assign w_wd_wide = {{DATA_W{1'b0}}, bus.req_wdata} << {w_off, 3'b000};
  assign w_addr_unused = &{1'b0, bus.req_addr[ADDR_W-1:OFF+AW]};

`ifdef DMEM_SPLIT_EN
  dmem_state_t         r_state;
  dmem_state_t         w_state_nxt;
  logic [AW-1:0]       r_hi_idx;
  logic [LANES-1:0]    r_hi_be;
  logic [DATA_W-1:0]   r_hi_data;
  logic                r_hi_we;
  logic [DATA_W-1:0]   r_raw_hi;

  assign w_err      = !w_legal;
  assign w_split    = w_legal && w_cross;
  assign w_in_split = (r_state == ST_SPLIT);
  assign bus.req_ready = (r_state == ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && w_split) w_state_nxt = ST_SPLIT;
      ST_SPLIT: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Upper half of a crossing access is parked here for the SPLIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_hi_idx  <= '0;
      r_hi_be   <= '0;
      r_hi_data <= '0;
      r_hi_we   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && w_split) begin
        r_hi_idx  <= w_idx + AW'(1);
        r_hi_be   <= w_be_wide[2*LANES-1:LANES];
        r_hi_data <= w_wd_wide[2*DATA_W-1:DATA_W];
        r_hi_we   <= bus.req_we;
      end
    end
  end
`else
  logic w_hi_unused;

  assign w_err      = !w_legal || w_misal;
  assign w_split    = 1'b0;
  assign w_in_split = 1'b0;
  assign bus.req_ready = 1'b1;
  assign w_hi_unused = ^{w_be_wide[2*LANES-1:LANES], w_wd_wide[2*DATA_W-1:DATA_W], w_cross};
`endif

  always_comb begin
    w_mem_idx = w_idx;
    w_wr_en   = w_accept && bus.req_we && !w_err;
    w_wr_be   = w_be_wide[LANES-1:0];
    w_wr_data = w_wd_wide[DATA_W-1:0];
    w_rd_en   = w_accept && !bus.req_we && !w_err;
`ifdef DMEM_SPLIT_EN
    if (r_state == ST_SPLIT) begin
      w_mem_idx = r_hi_idx;
      w_wr_en   = r_hi_we;
      w_wr_be   = r_hi_be;
      w_wr_data = r_hi_data;
      w_rd_en   = !r_hi_we;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int l = 0; l < LANES; l++)
        if (w_wr_be[l]) mem[w_mem_idx][8*l +: 8] <= w_wr_data[8*l +: 8];
    end
    if (w_rd_en && !w_in_split) r_raw_lo <= mem[w_mem_idx];
`ifdef DMEM_SPLIT_EN
    if (w_rd_en && w_in_split) r_raw_hi <= mem[w_mem_idx];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_load      <= 1'b0;
      r_off       <= '0;
      r_func3     <= '0;
    end else begin
      r_rsp_valid <= (w_accept && !w_split) || w_in_split;
      if (w_accept) begin
        r_err   <= w_err;
        r_load  <= !bus.req_we;
        r_off   <= w_off;
        r_func3 <= bus.req_func3;
      end
    end
  end

  dmem_load_align #(.DATA_W(DATA_W)) u_align (
`ifdef DMEM_SPLIT_EN
    .raw_hi (r_raw_hi),
`else
    .raw_hi ('0),
`endif
    .raw_lo (r_raw_lo),
    .off    (r_off),
    .func3  (r_func3),
    .result (w_aligned)
  );

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_valid && r_err;
  assign bus.rsp_rdata = (r_rsp_valid && r_load && !r_err) ? w_aligned : '0;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// Module : tb_data_mem_ctrl
// Brief  : Directed self-checking bench for data_mem_ctrl (DMEM_SPLIT_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;
  import dmem_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  data_mem_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_total = 0;
  int   n_bad   = 0;
  logic last_busy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_func3 = f3;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("ready_timeout", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0;
    last_busy = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus.req_ready) last_busy = 1'b1;
    end while (!bus.rsp_valid && lat < 8);
    if (!bus.rsp_valid) chk("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  task automatic op(input string tag, input logic we, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wd,
                    input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xfer(we, f3, addr, wd, rd, er, lat);
    chk({tag, ".rdata"}, 64'(rd), 64'(exp_rd));
    chk({tag, ".err"}, 64'(er), 64'(exp_err));
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_func3 = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 64'(bus.req_ready), 64'd1);
    chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst.rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst.err", 64'(bus.rsp_err), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Sub-word loads out of one stored word
    op("sw10",  1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1);
    op("lb13",  1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, 1);
    op("lbu13", 1'b0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0, 1);
    op("lhu12", 1'b0, F3_HU, 32'h12, 32'h0,        32'h0000DEAD, 1'b0, 1);
    op("lh12",  1'b0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, 1);
    op("lh10",  1'b0, F3_H,  32'h10, 32'h0,        32'hFFFFBEEF, 1'b0, 1);

    // Byte store touches only its lane
    op("sw20",  1'b1, F3_W,  32'h20, 32'h11223344, 32'h0,        1'b0, 1);
    op("sb21",  1'b1, F3_B,  32'h21, 32'h0000005A, 32'h0,        1'b0, 1);
    op("lw20",  1'b0, F3_W,  32'h20, 32'h0,        32'h11225A44, 1'b0, 1);

    // Back-to-back store then load
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_func3 = F3_W;
    bus.req_addr = 32'h0; bus.req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("b2b.sw_valid", 64'(bus.rsp_valid), 64'd1);
    chk("b2b.sw_err", 64'(bus.rsp_err), 64'd0);
    chk("b2b.ready", 64'(bus.req_ready), 64'd1);
    bus.req_we = 1'b0; bus.req_wdata = 32'h0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("b2b.lw_valid", 64'(bus.rsp_valid), 64'd1);
    chk("b2b.lw_rdata", 64'(bus.rsp_rdata), 64'hCAFEF00D);

    // Illegal func3 never writes
    op("sh_u",  1'b1, F3_HU, 32'h0,  32'h00001234, 32'h0,        1'b1, 1);
    op("ld_d",  1'b0, F3_D,  32'h0,  32'h0,        32'h0,        1'b1, 1);
    op("ld_7",  1'b0, 3'b111, 32'h0, 32'h0,        32'h0,        1'b1, 1);
    op("lw0a",  1'b0, F3_W,  32'h0,  32'h0,        32'hCAFEF00D, 1'b0, 1);
`ifndef DMEM_SPLIT_EN
    op("lw2",   1'b0, F3_W,  32'h2,  32'h0,        32'h0,        1'b1, 1);
    op("sh3",   1'b1, F3_H,  32'h3,  32'h0000FFFF, 32'h0,        1'b1, 1);
    op("lw0b",  1'b0, F3_W,  32'h0,  32'h0,        32'hCAFEF00D, 1'b0, 1);
`endif

    // Upper address bits are ignored
    op("sw_wrap", 1'b1, F3_W, 32'(DEPTH*4 + 'h30), 32'h0BADF00D, 32'h0, 1'b0, 1);
    op("lw30",    1'b0, F3_W, 32'h30, 32'h0, 32'h0BADF00D, 1'b0, 1);

`ifdef DMEM_SPLIT_EN
    op("sw0",   1'b1, F3_W,  32'h0, 32'h44332211, 32'h0,        1'b0, 1);
    op("sw4",   1'b1, F3_W,  32'h4, 32'h88776655, 32'h0,        1'b0, 1);
    op("lw3",   1'b0, F3_W,  32'h3, 32'h0,        32'h77665544, 1'b0, 2);
    chk("lw3.busy", 64'(last_busy), 64'd1);
    op("swlast", 1'b1, F3_W, 32'(DEPTH*4-4), 32'hAABBCCDD, 32'h0, 1'b0, 1);
    op("lwwrap", 1'b0, F3_W, 32'(DEPTH*4-2), 32'h0, 32'h2211AABB, 1'b0, 2);
    op("sw8",   1'b1, F3_W,  32'h8, 32'h00000000, 32'h0,        1'b0, 1);
    op("sw6",   1'b1, F3_W,  32'h6, 32'h0A0B0C0D, 32'h0,        1'b0, 2);
    op("lw4",   1'b0, F3_W,  32'h4, 32'h0,        32'h0C0D6655, 1'b0, 1);
    op("lw8",   1'b0, F3_W,  32'h8, 32'h0,        32'h00000A0B, 1'b0, 1);
    op("lh1",   1'b0, F3_H,  32'h1, 32'h0,        32'h00003322, 1'b0, 1);
    op("lhu3",  1'b0, F3_HU, 32'h3, 32'h0,        32'h00005544, 1'b0, 2);
`endif

    // Reset during an in-flight load drops its response
    @(negedge clk);
`ifdef DMEM_SPLIT_EN
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_func3 = F3_W; bus.req_addr = 32'h3;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort.split_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b0;
`else
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_func3 = F3_W; bus.req_addr = 32'h10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    rst_n = 1'b0;
`endif
    @(negedge clk);
    chk("abort.valid0", 64'(bus.rsp_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort.valid1", 64'(bus.rsp_valid), 64'd0);
    chk("abort.ready", 64'(bus.req_ready), 64'd1);
`ifdef DMEM_SPLIT_EN
    op("lw_after", 1'b0, F3_W, 32'h0,  32'h0, 32'h44332211, 1'b0, 1);
`else
    op("lw_after", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
